// File: rtl/ram_bus_arbiter.sv
// RAM bus arbiter for the stepper-clocked CPU.
// Three requesters share one RAM address/data bus:
//   0 = ROM-to-RAM loader (highest priority, never preempted)
//   1 = CPU control unit
//   2 = debug/monitor port
// Requesters 1 and 2 alternate round-robin when both are waiting. Every change
// of owner passes through one GAP step with no owner, so two drivers never
// overlap on the bus.
//
// Request/grant handshake: a requester raises req[i] and holds it high for the
// whole transaction. The arbiter answers with the registered one-hot gnt[i].
// The grant appears at the earliest one step after req[i] is sampled in IDLE.
// Strobe requests (sa/rd/wr) from a requester reach the RAM only while that
// requester owns gnt. The transaction ends when the owner drops req[i], or
// when the arbiter withdraws gnt (preempt pulse). A preempted requester keeps
// req[i] high and competes again. A requester must not raise sa/rd/wr while
// its req is low. Doing so sets the sticky proto_err flag.
module ram_bus_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int AW       = 8
) (
    input  logic          step_clk,
    input  logic          reset,
    input  logic          clk_e,
    input  logic          clk_s,
    input  logic [2:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [2:0]    sa_req,
    input  logic [2:0]    rd_req,
    input  logic [2:0]    wr_req,
    output logic [2:0]    gnt,
    output logic          bus_busy,
    output logic [AW-1:0] ram_address,
    output logic          set_address,
    output logic          enable_ram,
    output logic          set_ram,
    output logic          preempt,
    output logic          proto_err,
    output logic [1:0]    dbg_state,
    output logic [7:0]    dbg_hold_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // The hold limit is compared as "reached or passed". An owner that has
    // already held the bus past the limit without contention is therefore
    // released as soon as someone else starts waiting.
    localparam bit         PREEMPT_EN = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LIM   = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [1:0] rr_last;

    logic [2:0] winner;
    logic       owner_req;
    logic       others_waiting;
    logic       preempt_now;
    logic       owner_sa;
    logic       owner_rd;
    logic       owner_wr;
    logic       stray_strobe;
    logic       proto_viol;

    // Pick the next owner: loader first, then round-robin between 1 and 2
    always_comb begin
        winner = 3'b000;
        if (req[0]) begin
            winner = 3'b001;
        end else if (req[1] && req[2]) begin
            winner = (rr_last == 2'd1) ? 3'b100 : 3'b010;
        end else if (req[1]) begin
            winner = 3'b010;
        end else if (req[2]) begin
            winner = 3'b100;
        end
    end

    // Owner status, preemption decision and protocol-violation detection
    always_comb begin
        owner_req      = |(req & gnt);
        others_waiting = |(req & ~gnt);
        preempt_now    = PREEMPT_EN && !gnt[0] && (hold_cnt >= HOLD_LIM) && others_waiting;
        owner_sa       = |(sa_req & gnt);
        owner_rd       = |(rd_req & gnt);
        owner_wr       = |(wr_req & gnt);
        stray_strobe   = |((sa_req | rd_req | wr_req) & ~gnt & ~req);
        proto_viol     = (owner_sa && owner_wr) || stray_strobe;
    end

    // Route the owner's address and phase-gated strobes to the RAM
    always_comb begin
        case (gnt)
            3'b001:  ram_address = addr0;
            3'b010:  ram_address = addr1;
            3'b100:  ram_address = addr2;
            default: ram_address = '0;
        endcase
        set_address = owner_sa && clk_s;
        enable_ram  = owner_rd && clk_e;
        // An address set and a write in the same step conflict. The address set wins.
        set_ram     = owner_wr && clk_s && !owner_sa;
    end

    // Arbiter FSM: grant register, hold counter, round-robin pointer, flags
    always_ff @(posedge step_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            gnt       <= 3'b000;
            hold_cnt  <= 8'd0;
            rr_last   <= 2'd2;
            preempt   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            preempt <= 1'b0;
            if (proto_viol) begin
                proto_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (winner != 3'b000) begin
                        gnt      <= winner;
                        hold_cnt <= 8'd0;
                        state    <= ST_GRANT;
                        // Only requesters 1 and 2 take part in the rotation
                        if (winner[1]) begin
                            rr_last <= 2'd1;
                        end else if (winner[2]) begin
                            rr_last <= 2'd2;
                        end
                    end
                end
                ST_GRANT: begin
                    if (!owner_req) begin
                        gnt   <= 3'b000;
                        state <= ST_GAP;
                    end else if (preempt_now) begin
                        gnt     <= 3'b000;
                        state   <= ST_GAP;
                        preempt <= 1'b1;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= 3'b000;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Busy covers both the owned steps and the turnaround step
    always_comb begin
        bus_busy     = (state == ST_GRANT) || (state == ST_GAP);
        dbg_state    = state;
        dbg_hold_cnt = hold_cnt;
    end

endmodule
